branch_predict_unit: RTL
========================

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand width in bits.
REQ-002 The block SHALL have parameter BHT_DEPTH, default 16, meaning branch-history-table entries (power of two, >=2); IDX_W = log2(BHT_DEPTH).
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning statistics counter width.
REQ-004 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port fetch_pc  input  32  fetch-stage PC for prediction lookup.
REQ-007 The block SHALL have port pred_taken  output  1  combinational prediction for fetch_pc.
REQ-008 The block SHALL have port br_valid  input  1  decode-stage instruction present.
REQ-009 The block SHALL have ports br_pc  input  32; opcode  input  6; rt  input  5; rs_val  input  WIDTH; rt_val  input  WIDTH; pred_in  input  1 (prediction made at fetch).
REQ-010 The block SHALL have ports stall  input  1 and flush  input  1, decode-stage hold and squash.
REQ-011 The block SHALL have outputs res_valid 1, res_taken 1, res_mispredict 1, res_link 1 (all registered).
REQ-012 The block SHALL have outputs br_count CNT_W and mis_count CNT_W (registered).

Function
REQ-013 Condition decode, signed WIDTH compare: 000100 beq rs==rt; 000101 bne rs!=rt; 000110 blez rs<=0; 000111 bgtz rs>0; 000001 with rt=00000 bltz rs<0, 00001 bgez rs>=0, 10000 bltzal rs<0, 10001 bgezal rs>=0.
REQ-014 Any other opcode/rt combination SHALL be non-branch: not accepted, no result, no table or counter update.
REQ-015 Accept = br_valid & branch opcode & ~stall & ~flush; flush overrides stall and br_valid.
REQ-016 On accept at edge N: res_valid=1 during cycle N..N+1; res_taken=condition; res_mispredict=condition XOR pred_in; res_link=1 only for bltzal/bgezal (regardless of taken).
REQ-017 Without accept at an edge, res_valid SHALL be 0 next cycle; res_taken, res_mispredict, res_link SHALL be 0 whenever res_valid=0.
REQ-018 Latency: exactly one cycle from accepting edge to res_valid; back-to-back accepts give consecutive res_valid pulses.
REQ-019 BHT: BHT_DEPTH 2-bit saturating counters indexed by pc[IDX_W+1:2]; pred_taken = bit 1 of entry at fetch_pc index.
REQ-020 On the accepting edge the entry at br_pc index SHALL update: taken -> +1 saturating at 3; not taken -> -1 saturating at 0.
REQ-021 Lookup and update to the same index in the same cycle SHALL return the pre-update value (no bypass).
REQ-022 br_count SHALL increment on each accept; mis_count on each accept with mispredict; both saturate at all-ones (no wrap).
REQ-023 stall=1 SHALL hold table and counters unchanged (no accept).

Reset
REQ-024 While reset_n=0, asynchronously: all BHT entries = 2'b01 (weakly not-taken), res_* = 0, br_count = mis_count = 0.
REQ-025 Reset asserted mid-operation SHALL discard any pending result; first accept after release behaves as from power-up.
REQ-026 After reset, pred_taken SHALL read 0 for every fetch_pc.

Verification
REQ-027 Reset, then beq br_pc=0x3000 rs=5 rt=5 pred_in=0 -> next cycle res_valid=1 res_taken=1 res_mispredict=1; br_count=1 mis_count=1; pred_taken for fetch_pc=0x3000 becomes 1.
REQ-028 bgez rs=0xFFFFFFFF (-1), pred_in=0 -> res_taken=0 res_mispredict=0; bgezal rs=0 -> res_taken=1 res_link=1.
REQ-029 Four taken beq at 0x3004 -> entry saturates at 3; then three not-taken -> entry 0, pred_taken=0 (saturation both ends).
REQ-030 br_valid=1 with stall=1, then flush=1 -> no res_valid, counters unchanged; opcode 000000 with br_valid=1 -> no res_valid.
REQ-031 CNT_W=4: 16 mispredicted branches -> mis_count=15 and held at 15; reset_n pulse mid-burst -> res_valid=0 immediately, counts 0.
REQ-032 fetch_pc and br_pc both 0x3008, entry 01, taken accept same cycle -> pred_taken=0 that cycle, 1 next cycle.

Source files
------------

// File: rtl/branch_predict_unit.sv
// ============================================================================
// Module   : branch_predict_unit
// Purpose  : Decode-stage branch resolver with a 2-bit BHT fetch predictor and
//            branch/mispredict statistics counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_predict_unit #(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      fetch_pc,
  output logic             pred_taken,
  input  logic             br_valid,
  input  logic [31:0]      br_pc,
  input  logic [5:0]       opcode,
  input  logic [4:0]       rt,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             pred_in,
  input  logic             stall,
  input  logic             flush,
  output logic             res_valid,
  output logic             res_taken,
  output logic             res_mispredict,
  output logic             res_link,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mis_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  localparam logic [1:0] BHT_INIT  = 2'b01;
  localparam logic [1:0] BHT_MAX   = 2'b11;
  localparam logic [1:0] BHT_MIN   = 2'b00;

  localparam logic signed [WIDTH-1:0] ZERO = '0;
  localparam logic [CNT_W-1:0]        CNT_MAX = '1;

  logic [1:0]       bht_q [BHT_DEPTH];
  logic [1:0]       bht_d [BHT_DEPTH];
  logic [CNT_W-1:0] br_count_q,  br_count_d;
  logic [CNT_W-1:0] mis_count_q, mis_count_d;
  logic             res_valid_q, res_taken_q, res_mispredict_q, res_link_q;

  logic             is_branch;
  logic             cond;
  logic             link;
  logic             accept;
  logic             mispredict;
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] upd_idx;

  logic signed [WIDTH-1:0] rs_s;
  logic signed [WIDTH-1:0] rt_s;

  assign rs_s = $signed(rs_val);
  assign rt_s = $signed(rt_val);

  // Condition decode; anything not listed is treated as a non-branch.
  always_comb begin
    is_branch = 1'b0;
    cond      = 1'b0;
    link      = 1'b0;
    case (opcode)
      OP_BEQ: begin
        is_branch = 1'b1;
        cond      = (rs_s == rt_s);
      end
      OP_BNE: begin
        is_branch = 1'b1;
        cond      = (rs_s != rt_s);
      end
      OP_BLEZ: begin
        is_branch = 1'b1;
        cond      = (rs_s <= ZERO);
      end
      OP_BGTZ: begin
        is_branch = 1'b1;
        cond      = (rs_s > ZERO);
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ: begin
            is_branch = 1'b1;
            cond      = (rs_s < ZERO);
          end
          RT_BGEZ: begin
            is_branch = 1'b1;
            cond      = (rs_s >= ZERO);
          end
          RT_BLTZAL: begin
            is_branch = 1'b1;
            cond      = (rs_s < ZERO);
            link      = 1'b1;
          end
          RT_BGEZAL: begin
            is_branch = 1'b1;
            cond      = (rs_s >= ZERO);
            link      = 1'b1;
          end
          default: begin
            is_branch = 1'b0;
          end
        endcase
      end
      default: begin
        is_branch = 1'b0;
      end
    endcase
  end

  assign accept     = br_valid & is_branch & ~stall & ~flush;
  assign mispredict = cond ^ pred_in;

  assign fetch_idx  = fetch_pc[IDX_W+1:2];
  assign upd_idx    = br_pc[IDX_W+1:2];

  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  assign pred_taken = bht_q[fetch_idx][1];

  always_comb begin
    bht_d = bht_q;
    if (accept) begin
      if (cond) begin
        if (bht_q[upd_idx] != BHT_MAX) begin
          bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
        end
      end else begin
        if (bht_q[upd_idx] != BHT_MIN) begin
          bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
        end
      end
    end
  end

  always_comb begin
    br_count_d  = br_count_q;
    mis_count_d = mis_count_q;
    if (accept) begin
      if (br_count_q != CNT_MAX) begin
        br_count_d = br_count_q + CNT_W'(1);
      end
      if (mispredict && (mis_count_q != CNT_MAX)) begin
        mis_count_d = mis_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= BHT_INIT;
      end
    end else begin
      bht_q <= bht_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_count_q  <= '0;
      mis_count_q <= '0;
    end else begin
      br_count_q  <= br_count_d;
      mis_count_q <= mis_count_d;
    end
  end

  // Result fields are gated by accept so they read zero whenever res_valid is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid_q      <= 1'b0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
      res_link_q       <= 1'b0;
    end else begin
      res_valid_q      <= accept;
      res_taken_q      <= accept & cond;
      res_mispredict_q <= accept & mispredict;
      res_link_q       <= accept & link;
    end
  end

  assign res_valid      = res_valid_q;
  assign res_taken      = res_taken_q;
  assign res_mispredict = res_mispredict_q;
  assign res_link       = res_link_q;
  assign br_count       = br_count_q;
  assign mis_count      = mis_count_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0],
                            br_pc[31:IDX_W+2], br_pc[1:0]};

endmodule

`default_nettype wire
